seq_pair_loader: RTL and testbench
==================================

SEQ_PAIR_LOADER -- requirements
Module: seq_pair_loader

Interface
REQ-001 Parameter BUF_WIDTH, default 4, symbol width in bits written to each sequence buffer.
REQ-002 Parameter SEQ_LEN, default 63, symbols per sequence (63 x 4 = 252-bit arranged word).
REQ-003 Parameter CNT_W, default 6, width of the symbol counter; SHALL satisfy 2^CNT_W > SEQ_LEN.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst_SC  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to load one ref/read pair.
REQ-007 abort  input  1  cancels the current pair load.
REQ-008 in_valid  input  1  host symbol valid.
REQ-009 in_data  input  BUF_WIDTH  host symbol.
REQ-010 in_ready  output  1  loader accepts in_data this cycle.
REQ-011 buf1_full  input  1  ref buffer almost-full; asserts while at least one entry is still free.
REQ-012 buf2_full  input  1  read buffer almost-full; same semantics.
REQ-013 wr1_en  output  1  ref buffer write strobe.
REQ-014 wr2_en  output  1  read buffer write strobe.
REQ-015 buf1_in  output  BUF_WIDTH  ref buffer write data.
REQ-016 buf2_in  output  BUF_WIDTH  read buffer write data.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 pair_done  output  1  one-cycle pulse when both sequences of a pair have been written.
REQ-019 aborted  output  1  one-cycle pulse when a load is cancelled.
REQ-020 pair_cnt  output  16  count of completed pairs; saturates at 16'hFFFF.

Function
REQ-021 FSM states: IDLE, LOAD_REF, LOAD_READ, DONE.
REQ-022 IDLE -> LOAD_REF on start=1; symbol counter cleared to 0.
REQ-023 Handshake: a symbol transfers on a rising edge where in_valid=1 and in_ready=1.
REQ-024 in_ready = (state==LOAD_REF && !buf1_full) || (state==LOAD_READ && !buf2_full); combinational; 0 in IDLE and DONE.
REQ-025 LOAD_REF transfer: next cycle wr1_en=1 and buf1_in=transferred symbol; counter increments.
REQ-026 LOAD_READ transfer: next cycle wr2_en=1 and buf2_in=transferred symbol; counter increments.
REQ-027 Write latency exactly 1 cycle from the transfer edge; wr*_en high 1 cycle per symbol; at most one of wr1_en/wr2_en high in any cycle.
REQ-028 When the transfer taking the counter to SEQ_LEN occurs in LOAD_REF: LOAD_REF -> LOAD_READ, counter cleared to 0.
REQ-029 When the transfer taking the counter to SEQ_LEN occurs in LOAD_READ: LOAD_READ -> DONE.
REQ-030 DONE: pair_done=1 for exactly one cycle, pair_cnt increments (saturating), then -> IDLE.
REQ-031 Symbol order preserved; first host symbol of a sequence is the first write to its buffer.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 abort in LOAD_REF or LOAD_READ -> IDLE next edge, aborted pulses 1 cycle, pair_cnt unchanged; abort takes priority over a same-cycle transfer (in_ready forced to 0 while abort=1).
REQ-034 abort in IDLE or DONE SHALL be ignored; DONE completes normally.
REQ-035 A write strobe pending from the previous cycle SHALL still issue when abort is taken.
REQ-036 buf*_full high with in_valid=1: no transfer, counter and state hold, no write strobe.

Reset
REQ-037 rst_SC=1 asynchronously forces state=IDLE, counter=0, pair_cnt=0.
REQ-038 During reset: in_ready, wr1_en, wr2_en, busy, pair_done and aborted are 0; buf1_in and buf2_in are 0.
REQ-039 Reset mid-load discards the partial pair with no aborted pulse; the first start after reset release begins a fresh pair.

Verification
REQ-040 Nominal: start, 126 back-to-back symbols 0..15 repeating -> 63 wr1_en strobes, then 63 wr2_en strobes with the same data order, each 1 cycle after its transfer; pair_done 1 cycle after the last transfer; pair_cnt=1.
REQ-041 Backpressure: buf1_full held high for 10 cycles at symbol 20 -> in_ready=0, no wr1_en, counter holds at 20; load resumes with no lost or duplicated symbol.
REQ-042 Abort: abort with in_valid=1 at read symbol 30 -> no transfer that cycle; aborted pulses; IDLE; pair_cnt unchanged; next start loads a full pair.
REQ-043 Start while busy: start pulses at ref symbol 5 -> no effect; exactly 126 writes and one pair_done.
REQ-044 Async reset mid-LOAD_READ (not clock-aligned) -> all outputs 0 immediately; busy=0; pair_cnt=0.
REQ-045 Saturation: pair_cnt preloaded to 16'hFFFE (force), two pairs completed -> pair_cnt=16'hFFFF after each.

Source files
------------

// File: rtl/seq_pair_loader_if.sv
// Host/buffer-side signal bundle for the ref/read pair loader.
// master: the environment (host stream, buffer flags, observers).
// slave:  the loader itself.
interface seq_pair_loader_if #(
  parameter int BUF_WIDTH = 4
);
  logic                 start;
  logic                 abort;
  logic                 in_valid;
  logic [BUF_WIDTH-1:0] in_data;
  logic                 in_ready;
  logic                 buf1_full;
  logic                 buf2_full;
  logic                 wr1_en;
  logic                 wr2_en;
  logic [BUF_WIDTH-1:0] buf1_in;
  logic [BUF_WIDTH-1:0] buf2_in;
  logic                 busy;
  logic                 pair_done;
  logic                 aborted;
  logic [15:0]          pair_cnt;

  modport master (
    output start, abort, in_valid, in_data, buf1_full, buf2_full,
    input  in_ready, wr1_en, wr2_en, buf1_in, buf2_in,
           busy, pair_done, aborted, pair_cnt
  );

  modport slave (
    input  start, abort, in_valid, in_data, buf1_full, buf2_full,
    output in_ready, wr1_en, wr2_en, buf1_in, buf2_in,
           busy, pair_done, aborted, pair_cnt
  );
endinterface

// File: rtl/seq_pair_loader.sv
// Loads one reference sequence then one read sequence (SEQ_LEN symbols
// each) from a valid/ready host stream into two sequence buffers.
// Writes land one cycle after the accepting edge; a completed pair pulses
// pair_done and bumps a saturating pair counter.
module seq_pair_loader #(
  parameter int BUF_WIDTH = 4,
  parameter int SEQ_LEN   = 63,
  parameter int CNT_W     = 6
) (
  input logic             clk,
  input logic             rst_SC,
  seq_pair_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_REF  = 2'd1,
    LOAD_READ = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SEQ_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]          pair_cnt_q;
  logic                 in_ready_c;
  logic                 xfer;
  logic                 last_sym;
  logic                 loading;
  logic                 abort_take;

  // write pipeline: one register stage between acceptance and buffer strobe
  logic                 wr1_q, wr2_q;
  logic [BUF_WIDTH-1:0] buf1_q, buf2_q;
  logic                 aborted_q;

  // Handshake qualification; abort masks in_ready so it wins over a transfer.
  always_comb begin
    loading    = (state_q == LOAD_REF) || (state_q == LOAD_READ);
    abort_take = loading && bus.abort;
    in_ready_c = !bus.abort &&
                 (((state_q == LOAD_REF)  && !bus.buf1_full) ||
                  ((state_q == LOAD_READ) && !bus.buf2_full));
    xfer       = bus.in_valid && in_ready_c;
    last_sym   = (cnt_q == LAST_IDX);
  end

  // Next-state and symbol counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD_REF;
          cnt_d   = '0;
        end
      end
      LOAD_REF: begin
        if (abort_take) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (xfer) begin
          if (last_sym) begin
            state_d = LOAD_READ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD_READ: begin
        if (abort_take) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (xfer) begin
          if (last_sym) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst_SC) begin
    if (rst_SC) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Completed-pair counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst_SC) begin
    if (rst_SC) begin
      pair_cnt_q <= '0;
    end else if ((state_q == DONE) && (pair_cnt_q != 16'hFFFF)) begin
      pair_cnt_q <= pair_cnt_q + 16'd1;
    end
  end

  // Buffer write stage; a strobe already in flight still issues on abort.
  always_ff @(posedge clk or posedge rst_SC) begin
    if (rst_SC) begin
      wr1_q  <= 1'b0;
      wr2_q  <= 1'b0;
      buf1_q <= '0;
      buf2_q <= '0;
    end else begin
      wr1_q <= xfer && (state_q == LOAD_REF);
      wr2_q <= xfer && (state_q == LOAD_READ);
      if (xfer && (state_q == LOAD_REF))  buf1_q <= bus.in_data;
      if (xfer && (state_q == LOAD_READ)) buf2_q <= bus.in_data;
    end
  end

  // Abort acknowledge pulse, coincident with the first IDLE cycle.
  always_ff @(posedge clk or posedge rst_SC) begin
    if (rst_SC) aborted_q <= 1'b0;
    else        aborted_q <= abort_take;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.wr1_en    = wr1_q;
  assign bus.wr2_en    = wr2_q;
  assign bus.buf1_in   = buf1_q;
  assign bus.buf2_in   = buf2_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.pair_done = (state_q == DONE);
  assign bus.aborted   = aborted_q;
  assign bus.pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_seq_pair_loader.sv
// Scoreboard bench for seq_pair_loader: a phase-level reference model
// predicts handshake/status per cycle and queues expected buffer writes;
// an independent monitor pops the queue whenever a write strobe appears.
module tb_seq_pair_loader;
  localparam int BW      = 4;
  localparam int SEQ_LEN = 63;
  localparam int NSYM    = 2 * SEQ_LEN;

  logic clk    = 1'b0;
  logic rst_SC = 1'b1;

  seq_pair_loader_if #(.BUF_WIDTH(BW)) bus ();

  seq_pair_loader #(.BUF_WIDTH(BW), .SEQ_LEN(SEQ_LEN), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_SC (rst_SC),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          b;
    logic [BW-1:0] d;
    int          due;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  // model state: 0 idle, 1 ref, 2 read, 3 done
  int  phase      = 0;
  int  nsym       = 0;
  int  done_since = 0;
  bit  ab_pend    = 1'b0;
  int  cnt_base   = 0;   // owned by the stimulus process (counter preload)

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model, sampled mid-cycle when all inputs are settled.
  always @(negedge clk) begin : model
    bit  er, xf;
    int  ec;
    wr_t w;
    if (rst_SC) begin
      chk("reset_outs", 32'({bus.in_ready, bus.wr1_en, bus.wr2_en, bus.busy,
                             bus.pair_done, bus.aborted, bus.buf1_in,
                             bus.buf2_in, bus.pair_cnt}), 32'd0);
      phase = 0; nsym = 0; done_since = 0; ab_pend = 1'b0;
      exp_q.delete();
    end else begin
      er = !bus.abort && ((phase == 1 && !bus.buf1_full) ||
                          (phase == 2 && !bus.buf2_full));
      ec = cnt_base + done_since;
      if (ec > 65535) ec = 65535;
      chk("in_ready",  32'(bus.in_ready),  32'(er));
      chk("busy",      32'(bus.busy),      32'(phase != 0));
      chk("pair_done", 32'(bus.pair_done), 32'(phase == 3));
      chk("aborted",   32'(bus.aborted),   32'(ab_pend));
      chk("pair_cnt",  32'(bus.pair_cnt),  32'(ec));
      ab_pend = 1'b0;
      xf = bus.in_valid && er;
      case (phase)
        0: if (bus.start) begin phase = 1; nsym = 0; end
        1, 2: begin
          if (bus.abort) begin
            phase = 0; ab_pend = 1'b1;
          end else if (xf) begin
            w.b = phase; w.d = bus.in_data; w.due = cyc + 1;
            exp_q.push_back(w);
            nsym++;
            if (nsym == SEQ_LEN) begin
              nsym  = 0;
              phase = (phase == 1) ? 2 : 3;
            end
          end
        end
        default: begin phase = 0; done_since++; end
      endcase
    end
  end

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst_SC) begin
      chk("wr_exclusive", 32'(bus.wr1_en & bus.wr2_en), 32'd0);
      if (bus.wr1_en || bus.wr2_en) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wr", 32'({bus.wr1_en, bus.wr2_en}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_buf",     32'(bus.wr1_en ? 1 : 2), 32'(e.b));
          chk("wr_data",    32'(bus.wr1_en ? bus.buf1_in : bus.buf2_in), 32'(e.d));
          chk("wr_latency", 32'(cyc), 32'(e.due));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_wr", 32'({bus.wr1_en, bus.wr2_en}), 32'(e.b));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One pair attempt; *_at are global symbol indices (ref 0..62, read 63..125), -1 = unused.
  task automatic run_pair(input bit rnd, input int bp_at, input int ab_at,
                          input int st_at, input int rst_at);
    int i = 0, guard = 0, bp_left = 0;
    bit bp_done = 1'b0, have = 1'b0, acc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (i < NSYM) begin
      if (!have) begin
        bus.in_data = rnd ? BW'($urandom) : BW'(i % 16);
        have = 1'b1;
      end
      bus.in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.buf1_full = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      bus.buf2_full = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (i == bp_at && !bp_done) begin bp_left = 10; bp_done = 1'b1; end
      if (bp_left > 0) begin
        bus.buf1_full = 1'b1; bus.in_valid = 1'b1; bp_left--;
      end
      if (i == st_at) bus.start = 1'b1;
      if (i == ab_at) begin
        bus.abort = 1'b1; bus.in_valid = 1'b1;
        step();
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        repeat (3) step();
        return;
      end
      if (i == rst_at) begin
        #1 rst_SC = 1'b1;
        repeat (2) step();
        rst_SC = 1'b0; bus.in_valid = 1'b0;
        step();
        return;
      end
      @(negedge clk) acc = bus.in_valid && bus.in_ready;
      step();
      bus.start = 1'b0;
      if (acc) begin i++; have = 1'b0; end
      guard++;
      if (guard > 5000) begin
        $display("FAIL load_timeout: stuck at symbol %0d, need %0d", i, NSYM);
        $fatal(1, "load timeout");
      end
    end
    bus.in_valid = 1'b0; bus.buf1_full = 1'b0; bus.buf2_full = 1'b0;
    guard = 0;
    while (bus.busy) begin
      step();
      guard++;
      if (guard > 10) begin
        $display("FAIL idle_timeout: busy=%0d, need 0", bus.busy);
        $fatal(1, "idle timeout");
      end
    end
    step();
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.buf1_full = 1'b0; bus.buf2_full = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_SC = 1'b0;
    repeat (2) step();

    run_pair(1'b0, -1, -1, -1, -1);          // nominal, 0..15 repeating
    run_pair(1'b0, 20, -1, -1, -1);          // buf1_full for 10 cycles at symbol 20
    run_pair(1'b0, -1, SEQ_LEN + 30, -1, -1); // abort at read symbol 30
    run_pair(1'b0, -1, -1, -1, -1);          // full pair after abort
    run_pair(1'b0, -1, -1, 5, -1);           // start while busy
    bus.abort = 1'b1; step(); bus.abort = 1'b0; step();  // abort in IDLE
    repeat (3) run_pair(1'b1, -1, -1, -1, -1);
    run_pair(1'b0, -1, -1, -1, SEQ_LEN + 10); // async reset mid read
    run_pair(1'b1, -1, -1, -1, -1);

    // saturation: preload the pair counter just below the ceiling
    cnt_base = 65534 - done_since;
    force dut.pair_cnt_q = 16'hFFFE;
    #1 release dut.pair_cnt_q;
    step();
    repeat (2) run_pair(1'b1, -1, -1, -1, -1);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
